// File: rtl/ifu_fetch.sv
// Instruction fetch unit: turns core PCs into single-beat reads on a valid/ready
// instruction bus and hands the fetched word back to the core, one request in flight.
module ifu_fetch #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   input  logic        flush,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        fetch_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

   localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

   state_t      state, state_n;
   logic        valid_n, err_n, discard, discard_n, late_seen, late_n;
   logic [31:0] inst_n, pc_n, addr_n, cnt_n;
   logic [7:0]  timer, timer_n;
   logic        start, take_rsp, disc;

   assign mem_req_valid = (state == S_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         inst_valid   <= 1'b0;
         inst         <= NOP_INST;
         inst_pc      <= '0;
         fetch_err    <= 1'b0;
         mem_req_addr <= '0;
         fetch_cnt    <= '0;
         timer        <= '0;
         discard      <= 1'b0;
         late_seen    <= 1'b0;
      end else begin
         state        <= state_n;
         inst_valid   <= valid_n;
         inst         <= inst_n;
         inst_pc      <= pc_n;
         fetch_err    <= err_n;
         mem_req_addr <= addr_n;
         fetch_cnt    <= cnt_n;
         timer        <= timer_n;
         discard      <= discard_n;
         late_seen    <= late_n;
      end
   end

   always_comb begin
      state_n   = state;
      valid_n   = inst_valid;
      inst_n    = inst;
      pc_n      = inst_pc;
      err_n     = fetch_err;
      addr_n    = mem_req_addr;
      cnt_n     = fetch_cnt;
      timer_n   = timer;
      discard_n = discard;
      late_n    = late_seen;
      start     = 1'b0;
      take_rsp  = 1'b0;
      disc      = discard | flush;

      case (state)
         S_IDLE: start = pc_valid;
         S_REQ: begin
            discard_n = disc;
            if (mem_req_ready) begin
               state_n  = S_WAIT;
               timer_n  = '0;
               // zero-wait memory may answer in the same cycle it accepts
               take_rsp = mem_rsp_valid;
            end
         end
         S_WAIT: begin
            discard_n = disc;
            if (mem_rsp_valid) begin
               take_rsp = 1'b1;
            end else if (timer == TMAX) begin
               discard_n = 1'b0;
               timer_n   = '0;
               if (disc) begin
                  state_n = S_IDLE;
               end else begin
                  state_n = S_DRAIN;
                  valid_n = 1'b1;
                  inst_n  = NOP_INST;
                  err_n   = 1'b1;
                  late_n  = 1'b0;
               end
            end else begin
               timer_n = timer + 8'd1;
            end
         end
         S_DONE: begin
            if (flush) begin
               valid_n = 1'b0;
               inst_n  = NOP_INST;
               err_n   = 1'b0;
               state_n = S_IDLE;
            end else if (inst_ready) begin
               if (!fetch_err) cnt_n = fetch_cnt + 32'd1;
               valid_n = 1'b0;
               state_n = S_IDLE;
               start   = pc_valid;
            end
         end
         S_DRAIN: begin
            if (flush) begin
               valid_n = 1'b0;
               inst_n  = NOP_INST;
               err_n   = 1'b0;
            end else if (inst_valid && inst_ready) begin
               valid_n = 1'b0;
            end
            late_n = late_seen | mem_rsp_valid;
            if (timer != TMAX) timer_n = timer + 8'd1;
            // leave only once the core is done and the bus can no longer answer
            if (!valid_n && (late_n || timer == TMAX)) begin
               state_n = S_IDLE;
               late_n  = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (take_rsp) begin
         discard_n = 1'b0;
         if (disc) begin
            state_n = S_IDLE;
         end else begin
            state_n = S_DONE;
            valid_n = 1'b1;
            err_n   = mem_rsp_err;
            inst_n  = mem_rsp_err ? NOP_INST : mem_rsp_data;
         end
      end

      if (start) begin
         pc_n = pc;
         if (pc[1:0] == 2'b00) begin
            addr_n    = pc;
            valid_n   = 1'b0;
            discard_n = 1'b0;
            state_n   = S_REQ;
         end else begin
            inst_n  = NOP_INST;
            err_n   = 1'b1;
            valid_n = 1'b1;
            state_n = S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_ifu_fetch;

   localparam logic [31:0] NOP     = 32'h00000013;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst, pc_valid, flush, inst_ready;
   logic [31:0] pc;
   logic        inst_valid, fetch_err, mem_req_valid;
   logic [31:0] inst, inst_pc, mem_req_addr, fetch_cnt;
   logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
   logic [31:0] mem_rsp_data;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] exp_cnt = '0;

   ifu_fetch #(.NOP_INST(NOP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .fetch_err(fetch_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc = 32'h0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      #1;
      step(); step();
      rst = 1'b0;
      checks++;
      if (inst !== NOP || inst_valid !== 1'b0 || mem_req_valid !== 1'b0 || fetch_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset inst=%h valid=%b req=%b cnt=%0d exp inst=%h valid=0 req=0 cnt=0",
                  inst, inst_valid, mem_req_valid, fetch_cnt, NOP);
      end
      checks++;
      if (inst_pc !== 32'h0 || fetch_err !== 1'b0 || mem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs inst_pc=%h err=%b addr=%h exp 0/0/0", inst_pc, fetch_err, mem_req_addr);
      end
   endtask

   task automatic test_zero_wait();
      pc = 32'h80000000; pc_valid = 1'b1; inst_ready = 1'b1;
      step();
      pc_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80000000) begin
         errors++;
         $display("FAIL zw_req valid=%b addr=%h exp 1 80000000", mem_req_valid, mem_req_addr);
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00100093; mem_rsp_err = 1'b0;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'hA5A5A5A5;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00100093 || inst_pc !== 32'h80000000 || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL zw_inst valid=%b inst=%h pc=%h err=%b exp 1 00100093 80000000 0",
                  inst_valid, inst, inst_pc, fetch_err);
      end
      step();
      inst_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (inst_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL zw_cnt valid=%b cnt=%0d exp 0 %0d", inst_valid, fetch_cnt, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      pc = 32'h80000000; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; pc = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80000000) begin
            errors++;
            $display("FAIL b2b_stall%0d valid=%b addr=%h exp 1 80000000", i, mem_req_valid, mem_req_addr);
         end
         step();
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00200113;
      step();
      mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst !== 32'h00200113 || inst_pc !== 32'h80000000) begin
            errors++;
            $display("FAIL b2b_hold%0d valid=%b inst=%h pc=%h exp 1 00200113 80000000",
                     i, inst_valid, inst, inst_pc);
         end
         step();
      end
      inst_ready = 1'b1; pc = 32'h80000004; pc_valid = 1'b1;
      step();
      inst_ready = 1'b0; pc_valid = 1'b0;
      exp_cnt++;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80000004 || inst_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL b2b_second req=%b addr=%h valid=%b cnt=%0d exp 1 80000004 0 %0d",
                  mem_req_valid, mem_req_addr, inst_valid, fetch_cnt, exp_cnt);
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00308193;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00308193 || inst_pc !== 32'h80000004) begin
         errors++;
         $display("FAIL b2b_inst2 valid=%b inst=%h pc=%h exp 1 00308193 80000004", inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL b2b_cnt got %0d exp %0d", fetch_cnt, exp_cnt);
      end
   endtask

   task automatic test_misaligned();
      pc = 32'h80000002; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b0 || inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== NOP || inst_pc !== 32'h80000002) begin
         errors++;
         $display("FAIL misaligned req=%b valid=%b err=%b inst=%h pc=%h exp 0 1 1 %h 80000002",
                  mem_req_valid, inst_valid, fetch_err, inst, inst_pc, NOP);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL misaligned_cnt valid=%b cnt=%0d exp 0 %0d", inst_valid, fetch_cnt, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      int unsigned n;
      pc = 32'h80000008; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      n = 0;
      while (inst_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_cycles got %0d exp %0d", n, TIMEOUT);
      end
      checks++;
      if (inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst !== NOP || inst_pc !== 32'h80000008) begin
         errors++;
         $display("FAIL timeout_inst valid=%b err=%b inst=%h pc=%h exp 1 1 %h 80000008",
                  inst_valid, fetch_err, inst, inst_pc, NOP);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0; pc = 32'h8000000C; pc_valid = 1'b1;
      step();
      checks++;
      if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_hold req=%b valid=%b exp 0 0", mem_req_valid, inst_valid);
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAADF00D;
      step();
      mem_rsp_valid = 1'b0;
      step();
      pc_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000000C || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_drain_req req=%b addr=%h valid=%b exp 1 8000000C 0", mem_req_valid, mem_req_addr, inst_valid);
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00410213;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00410213 || inst_pc !== 32'h8000000C || fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL post_drain_inst valid=%b inst=%h pc=%h err=%b exp 1 00410213 8000000C 0",
                  inst_valid, inst, inst_pc, fetch_err);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL timeout_cnt got %0d exp %0d", fetch_cnt, exp_cnt);
      end
   endtask

   task automatic test_flush();
      pc = 32'h80000014; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
      step();
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop%0d valid=%b req=%b inst=%h exp 0 0", i, inst_valid, mem_req_valid, inst);
         end
         step();
      end
      pc = 32'h80000010; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80000010) begin
         errors++;
         $display("FAIL flush_next_req valid=%b addr=%h exp 1 80000010", mem_req_valid, mem_req_addr);
      end
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A00113;
      step();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h00A00113 || inst_pc !== 32'h80000010) begin
         errors++;
         $display("FAIL flush_next_inst valid=%b inst=%h pc=%h exp 1 00A00113 80000010", inst_valid, inst, inst_pc);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_cnt++;
      checks++;
      if (fetch_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL flush_cnt got %0d exp %0d", fetch_cnt, exp_cnt);
      end
   endtask

   // Each transaction: expected word is what the bench's memory returned, or NOP on any error.
   task automatic test_random();
      logic [31:0] p, d, exp_inst;
      logic        mis, e, flushed;
      int unsigned rq, rl, hold;
      for (int t = 0; t < 40; t++) begin
         mis  = ($urandom_range(0, 4) == 0);
         p    = $urandom & 32'hFFFFFFFC;
         if (mis) p[1:0] = 2'($urandom_range(1, 3));
         d    = $urandom;
         e    = ($urandom_range(0, 7) == 0);
         rq   = $urandom_range(0, 3);
         rl   = $urandom_range(0, 3);
         hold = $urandom_range(0, 2);
         flushed  = ($urandom_range(0, 7) == 0);
         exp_inst = (mis || e) ? NOP : d;

         if ($urandom_range(0, 3) == 0) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
            step();
            mem_rsp_valid = 1'b0;
         end
         pc = p; pc_valid = 1'b1;
         step();
         pc_valid = 1'b0;
         if (!mis) begin
            for (int i = 0; i <= int'(rq); i++) begin
               checks++;
               if (mem_req_valid !== 1'b1 || mem_req_addr !== p) begin
                  errors++;
                  $display("FAIL rnd%0d_req valid=%b addr=%h exp 1 %h", t, mem_req_valid, mem_req_addr, p);
               end
               if (i < int'(rq)) step();
            end
            mem_req_ready = 1'b1;
            mem_rsp_valid = (rl == 0);
            mem_rsp_data  = (rl == 0) ? d : $urandom;
            mem_rsp_err   = e;
            step();
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            if (rl != 0) begin
               for (int k = 1; k < int'(rl); k++) begin
                  mem_rsp_data = $urandom;
                  step();
               end
               mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = e;
               step();
               mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = $urandom;
            end
         end
         for (int h = 0; h <= int'(hold); h++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== exp_inst || inst_pc !== p || fetch_err !== (mis | e)) begin
               errors++;
               $display("FAIL rnd%0d_inst valid=%b inst=%h pc=%h err=%b exp 1 %h %h %b",
                        t, inst_valid, inst, inst_pc, fetch_err, exp_inst, p, mis | e);
            end
            if (h < int'(hold)) step();
         end
         inst_ready = 1'b1; flush = flushed;
         step();
         inst_ready = 1'b0; flush = 1'b0;
         if (!flushed && !mis && !e) exp_cnt++;
         checks++;
         if (inst_valid !== 1'b0 || fetch_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL rnd%0d_cnt valid=%b cnt=%0d exp 0 %0d", t, inst_valid, fetch_cnt, exp_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_back_to_back();
      test_misaligned();
      test_timeout();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
